spi_ram: RTL and testbench



---
 rtl/spi_ram.sv | 148 ++++++++++++++
 tb/tb_spi_ram.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram.sv
// spi_ram: command-decoded single-port RAM that sits behind an SPI slave.
// Each accepted 10-bit word is {cmd[1:0], payload[7:0]}:
//   00 write address, 01 write data, 10 read address, 11 read data.
// Optional feature macro SPI_RAM_AUTOINC_EN: after each accepted data command
// the matching address register increments modulo MEM_DEPTH, and rd_addr_ok
// stays set so bursts can be read without re-sending an address.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    CMD_WADDR = 2'b00,
    CMD_WDATA = 2'b01,
    CMD_RADDR = 2'b10,
    CMD_RDATA = 2'b11
  } cmd_e;

  // Storage is deliberately not reset; only control state is.
  logic [7:0] mem [MEM_DEPTH];

  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_addr_ok_q, rd_addr_ok_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 mem_we;

  cmd_e       cmd;
  logic [7:0] payload;
  logic       accept;
  logic       rx_fall;
  logic       addr_in_range;

  assign cmd     = cmd_e'(rx_data[9:8]);
  assign payload = rx_data[7:0];

  // A word is taken exactly once, on the low-to-high transition of rx_valid;
  // holding rx_valid high for many cycles does not repeat the command.
  assign accept  = rx_valid & ~rx_valid_q;
  // Slave has finished shifting the response out; drop tx_valid next cycle.
  assign rx_fall = ~rx_valid & rx_valid_q;

  // Address payloads beyond the array are illegal (matters when MEM_DEPTH
  // is smaller than the 8-bit payload range).
  assign addr_in_range = int'(payload) < MEM_DEPTH;

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (int'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_SIZE'(1);
  endfunction
`endif

  // Command decode: next-state for address/flag/response registers.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_addr_ok_d = rd_addr_ok_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    err_d        = 1'b0;
    mem_we       = 1'b0;

    if (rx_fall) tx_valid_d = 1'b0;

    // Acceptance and a falling edge are mutually exclusive; acceptance
    // wins regardless and always retires any previous response.
    if (accept) begin
      tx_valid_d = 1'b0;
      unique case (cmd)
        CMD_WADDR: begin
          if (addr_in_range) wr_addr_d = payload[ADDR_SIZE-1:0];
          else               err_d     = 1'b1;
        end
        CMD_WDATA: begin
          mem_we = rst_n;
`ifdef SPI_RAM_AUTOINC_EN
          wr_addr_d = addr_inc(wr_addr_q);
`endif
        end
        CMD_RADDR: begin
          if (addr_in_range) begin
            rd_addr_d    = payload[ADDR_SIZE-1:0];
            rd_addr_ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RDATA: begin
          // Payload is a don't-care; a read needs a fresh read address.
          if (!rd_addr_ok_q) begin
            err_d = 1'b1;
          end else begin
            tx_data_d  = mem[rd_addr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d  = addr_inc(rd_addr_q);
`else
            rd_addr_ok_d = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Control and response registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_addr_ok_q <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_valid_q   <= rx_valid;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_addr_ok_q <= rd_addr_ok_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      err_q        <= err_d;
    end
  end

  // Memory write port; wr_addr is only ever loaded with in-range values.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= payload;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: two spi_ram instances (MEM_DEPTH 256 and 200) share the same
// word stream and are checked cycle by cycle against a command-level model.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] txd [2];
  logic       txv [2];
  logic       errs [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_d256 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(txd[0]), .tx_valid(txv[0]), .err(errs[0]));

  spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) u_d200 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(txd[1]), .tx_valid(txv[1]), .err(errs[1]));

  // Reference model state, one copy per instance
  bit [7:0]   m_mem [2][256];
  bit         m_kn  [2][256];
  int         m_wa [2], m_ra [2];
  bit         m_rok [2];
  bit         e_txv [2], e_err [2], e_tk [2];
  logic [7:0] e_txd [2];
  bit         prev_v;

  localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wa[k] = 0; m_ra[k] = 0; m_rok[k] = 0;
      e_txv[k] = 0; e_err[k] = 0; e_txd[k] = 8'h00; e_tk[k] = 1;
    end
    prev_v = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the command rules,
  // then move to 1 time unit after the clock edge.
  task automatic step(input bit v, input logic [9:0] d);
    bit acc, fal;
    int pl;
    rx_valid = v; rx_data = d;
    acc = v && !prev_v;
    fal = !v && prev_v;
    prev_v = v;
    pl = int'(d[7:0]);
    for (int k = 0; k < 2; k++) begin
      int dep;
      dep = (k == 0) ? 256 : 200;
      e_err[k] = 0;
      if (fal) e_txv[k] = 0;
      if (acc) begin
        e_txv[k] = 0;
        case (d[9:8])
          WA: if (pl < dep) m_wa[k] = pl; else e_err[k] = 1;
          WD: begin
            m_mem[k][m_wa[k]] = d[7:0];
            m_kn[k][m_wa[k]] = 1;
`ifdef SPI_RAM_AUTOINC_EN
            m_wa[k] = (m_wa[k] + 1) % dep;
`endif
          end
          RA: if (pl < dep) begin m_ra[k] = pl; m_rok[k] = 1; end else e_err[k] = 1;
          default: begin
            if (!m_rok[k]) e_err[k] = 1;
            else begin
              e_txv[k] = 1;
              e_txd[k] = m_mem[k][m_ra[k]];
              e_tk[k]  = m_kn[k][m_ra[k]];
`ifdef SPI_RAM_AUTOINC_EN
              m_ra[k] = (m_ra[k] + 1) % dep;
`else
              m_rok[k] = 0;
`endif
            end
          end
        endcase
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; rx_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (txv[k] !== 1'b0 || txd[k] !== 8'h00 || errs[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset dut%0d: got txv=%b txd=%h err=%b want 0 00 0", k, txv[k], txd[k], errs[k]);
      end
    end
    model_reset();
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_write_read();
    logic [9:0] w [$];
    do_reset();
    w = '{{WA, 8'h12}, {WD, 8'hA5}, {RA, 8'h12}, {RD, 8'h00}};
    foreach (w[i]) for (int c = 0; c < 2; c++) begin
      step(c == 0, w[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (errs[k] !== e_err[k] || txv[k] !== e_txv[k] || (e_tk[k] && txd[k] !== e_txd[k])) begin
          n_bad++;
          $display("FAIL wr_rd dut%0d w%0d c%0d: got err=%b txv=%b txd=%h want err=%b txv=%b txd=%h",
                   k, i, c, errs[k], txv[k], txd[k], e_err[k], e_txv[k], e_txd[k]);
        end
        if (i == 3 && c == 0) begin
          n_cmp++;
          if (txv[k] !== 1'b1 || txd[k] !== 8'hA5 || errs[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rd_const dut%0d: got txv=%b txd=%h err=%b want 1 a5 0", k, txv[k], txd[k], errs[k]);
          end
        end
      end
    end
  endtask

  task automatic test_held();
    logic [9:0] w [$];
    int h;
    w = '{{WA, 8'h06}, {WD, 8'h77}, {WA, 8'h05}, {WD, 8'h3C},
          {RA, 8'h05}, {RD, 8'h00}, {RA, 8'h06}, {RD, 8'h00}};
    foreach (w[i]) begin
      h = (i == 3) ? 12 : 1;
      for (int c = 0; c < h + 1; c++) begin
        step(c < h, w[i]);
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if (errs[k] !== e_err[k] || txv[k] !== e_txv[k] || (e_tk[k] && txd[k] !== e_txd[k])) begin
            n_bad++;
            $display("FAIL held dut%0d w%0d c%0d: got err=%b txv=%b txd=%h want err=%b txv=%b txd=%h",
                     k, i, c, errs[k], txv[k], txd[k], e_err[k], e_txv[k], e_txd[k]);
          end
          if ((i == 5 || i == 7) && c == 0) begin
            n_cmp++;
            if (txd[k] !== ((i == 5) ? 8'h3C : 8'h77)) begin
              n_bad++;
              $display("FAIL held_const dut%0d w%0d: got txd=%h want %h", k, i, txd[k], (i == 5) ? 8'h3C : 8'h77);
            end
          end
        end
      end
    end
  endtask

  task automatic test_read_noaddr();
    logic [9:0] w [$];
    do_reset();
    w = '{{RD, 8'h00}, {RA, 8'h14}, {RD, 8'h00}, {RD, 8'h00}};
    foreach (w[i]) for (int c = 0; c < 2; c++) begin
      step(c == 0, w[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (errs[k] !== e_err[k] || txv[k] !== e_txv[k] || (e_tk[k] && txd[k] !== e_txd[k])) begin
          n_bad++;
          $display("FAIL noaddr dut%0d w%0d c%0d: got err=%b txv=%b txd=%h want err=%b txv=%b txd=%h",
                   k, i, c, errs[k], txv[k], txd[k], e_err[k], e_txv[k], e_txd[k]);
        end
        if (i == 0 && c == 0) begin
          n_cmp++;
          if (errs[k] !== 1'b1 || txv[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL noaddr_const dut%0d: got err=%b txv=%b want 1 0", k, errs[k], txv[k]);
          end
        end
      end
    end
  endtask

  task automatic test_range();
    logic [9:0] w [$];
    w = '{{WA, 8'h10}, {WA, 8'hC8}, {WD, 8'h5A}, {RA, 8'h10}, {RD, 8'h00}, {RA, 8'hC8}, {RD, 8'h00}};
    foreach (w[i]) for (int c = 0; c < 2; c++) begin
      step(c == 0, w[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (errs[k] !== e_err[k] || txv[k] !== e_txv[k] || (e_tk[k] && txd[k] !== e_txd[k])) begin
          n_bad++;
          $display("FAIL range dut%0d w%0d c%0d: got err=%b txv=%b txd=%h want err=%b txv=%b txd=%h",
                   k, i, c, errs[k], txv[k], txd[k], e_err[k], e_txv[k], e_txd[k]);
        end
      end
      if (i == 1 && c == 0) begin
        n_cmp++;
        if (errs[1] !== 1'b1 || errs[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL range_err: got d200=%b d256=%b want 1 0", errs[1], errs[0]);
        end
      end
      if (i == 4 && c == 0) begin
        n_cmp++;
        if (txd[1] !== 8'h5A) begin
          n_bad++;
          $display("FAIL range_prev_addr: got %h want 5a", txd[1]);
        end
      end
    end
  endtask

  task automatic test_txvalid_life();
    logic [9:0] w [$];
    int h;
    w = '{{WA, 8'h28}, {WD, 8'h9E}, {RA, 8'h28}, {RD, 8'h00}};
    foreach (w[i]) begin
      h = (i == 3) ? 6 : 1;
      for (int c = 0; c < h + 2; c++) begin
        step(c < h, w[i]);
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if (errs[k] !== e_err[k] || txv[k] !== e_txv[k] || (e_tk[k] && txd[k] !== e_txd[k])) begin
            n_bad++;
            $display("FAIL txv_life dut%0d w%0d c%0d: got err=%b txv=%b txd=%h want err=%b txv=%b txd=%h",
                     k, i, c, errs[k], txv[k], txd[k], e_err[k], e_txv[k], e_txd[k]);
          end
        end
        if (i == 3) begin
          n_cmp++;
          if (txv[0] !== ((c < h) ? 1'b1 : 1'b0)) begin
            n_bad++;
            $display("FAIL txv_hold c%0d: got %b want %b", c, txv[0], (c < h) ? 1'b1 : 1'b0);
          end
        end
      end
    end
    // Reset while a response is pending clears it without a clock edge.
    step(1, {RA, 8'h28}); step(0, 10'h0); step(1, {RD, 8'h00});
    n_cmp++;
    if (txv[0] !== 1'b1 || txd[0] !== 8'h9E) begin
      n_bad++;
      $display("FAIL pre_rst: got txv=%b txd=%h want 1 9e", txv[0], txd[0]);
    end
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (txv[k] !== 1'b0 || txd[k] !== 8'h00) begin
        n_bad++;
        $display("FAIL async_rst dut%0d: got txv=%b txd=%h want 0 00", k, txv[k], txd[k]);
      end
    end
    model_reset();
    rx_valid = 1; rx_data = {WA, 8'h33};
    @(posedge clk); #1 rst_n = 1;
    // A word already high when reset releases counts as a new word.
    step(1, {WA, 8'h33}); step(0, 10'h0);
    step(1, {WD, 8'h44}); step(0, 10'h0);
    step(1, {RA, 8'h33}); step(0, 10'h0);
    step(1, {RD, 8'h00});
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (txv[k] !== 1'b1 || txd[k] !== 8'h44 || errs[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL rel_high dut%0d: got txv=%b txd=%h err=%b want 1 44 0", k, txv[k], txd[k], errs[k]);
      end
    end
    step(0, 10'h0);
  endtask

  task automatic test_autoinc();
    logic [9:0] w [$];
    w = '{{WA, 8'hFF}, {WD, 8'h11}, {WD, 8'h22}, {RA, 8'hFF}, {RD, 8'h00}, {RD, 8'h00}};
    foreach (w[i]) for (int c = 0; c < 2; c++) begin
      step(c == 0, w[i]);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (errs[k] !== e_err[k] || txv[k] !== e_txv[k] || (e_tk[k] && txd[k] !== e_txd[k])) begin
          n_bad++;
          $display("FAIL autoinc dut%0d w%0d c%0d: got err=%b txv=%b txd=%h want err=%b txv=%b txd=%h",
                   k, i, c, errs[k], txv[k], txd[k], e_err[k], e_txv[k], e_txd[k]);
        end
      end
`ifdef SPI_RAM_AUTOINC_EN
      if (i >= 4 && c == 0) begin
        n_cmp++;
        if (txd[0] !== ((i == 4) ? 8'h11 : 8'h22) || errs[0] !== 1'b0 || txv[0] !== 1'b1) begin
          n_bad++;
          $display("FAIL autoinc_burst w%0d: got txd=%h err=%b txv=%b want %h 0 1",
                   i, txd[0], errs[0], txv[0], (i == 4) ? 8'h11 : 8'h22);
        end
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [9:0] d;
    int h, g;
    for (int i = 0; i < 250; i++) begin
      d = 10'($urandom);
      h = $urandom_range(1, 3);
      g = $urandom_range(1, 2);
      for (int c = 0; c < h + g; c++) begin
        step(c < h, d);
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if (errs[k] !== e_err[k] || txv[k] !== e_txv[k] || (e_tk[k] && txd[k] !== e_txd[k])) begin
            n_bad++;
            $display("FAIL random dut%0d w%0d c%0d d=%h: got err=%b txv=%b txd=%h want err=%b txv=%b txd=%h",
                     k, i, c, d, errs[k], txv[k], txd[k], e_err[k], e_txv[k], e_txd[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held();
    test_read_noaddr();
    test_range();
    test_txvalid_life();
    test_autoinc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
